// File: rtl/ava_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ava_pixel_fetch
// Brief   : VRAM frame scanner, 1/2/4/8 bpp palette or 32 bpp direct -> 24b stream
// Revision: 1.0  initial release
// ============================================================================
module ava_pixel_fetch #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int VRAM_ADDR_WIDTH = 17,
    parameter int PRAM_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [2:0]                 bpp_sel,
    input  logic [VRAM_ADDR_WIDTH-1:0] frame_base,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_a,
    output logic                       vram_en,
    input  logic [31:0]                vram_d,
    output logic [PRAM_ADDR_WIDTH-1:0] pram_a,
    output logic                       pram_en,
    input  logic [31:0]                pram_d,
    output logic [23:0]                out_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       frame_done
);

    localparam int c_xw = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_yw = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_aw = VRAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      bpp_log_q;
    logic            mode32_q;
    logic [c_aw-1:0] stride_q, line_base_q, word_idx_q;
    logic [c_xw-1:0] x_q;
    logic [c_yw-1:0] y_q;
    logic [4:0]      sub_q;

    logic            s1_valid_q, s1_new_q, s1_sof_q, s1_eol_q;
    logic [4:0]      s1_sub_q;
    logic [31:0]     word_q;
    logic            s2_valid_q, s2_sof_q, s2_eol_q;
    logic [23:0]     s2_direct_q;
    logic            out_valid_q, out_sof_q, out_eol_q;
    logic [23:0]     out_pixel_q;

    logic            adv, issue, x_last, y_last, sub_last, pipe_empty;
    logic [4:0]      sub_max;
    logic [1:0]      sel_log;
    logic            sel_m32;
    logic [c_aw-1:0] sel_stride;
    logic [31:0]     w_word, w_shifted;
    logic [4:0]      w_shamt;
    logic [7:0]      w_mask, w_field;
    logic            w_unused;

    assign adv        = ~out_valid_q | out_ready;
    assign issue      = (state_q == S_RUN) & adv;
    assign x_last     = (x_q == c_xw'(H_RES - 1));
    assign y_last     = (y_q == c_yw'(V_RES - 1));
    assign sub_last   = (sub_q == sub_max);
    assign pipe_empty = ~s1_valid_q & ~s2_valid_q & ~out_valid_q;

    // Decode of the depth select; unsupported codes fall back to 8 bpp.
    always_comb begin
        sel_log    = 2'd3;
        sel_m32    = 1'b0;
        sel_stride = c_aw'(H_RES / 4);
        case (bpp_sel)
            3'd0:    begin sel_log = 2'd0; sel_stride = c_aw'(H_RES / 32); end
            3'd1:    begin sel_log = 2'd1; sel_stride = c_aw'(H_RES / 16); end
            3'd2:    begin sel_log = 2'd2; sel_stride = c_aw'(H_RES / 8);  end
            3'd4:    begin sel_m32 = 1'b1; sel_stride = c_aw'(H_RES);      end
            default: ;
        endcase
    end

    always_comb begin
        sub_max = 5'd0;
        if (!mode32_q) begin
            case (bpp_log_q)
                2'd0:    sub_max = 5'd31;
                2'd1:    sub_max = 5'd15;
                2'd2:    sub_max = 5'd7;
                default: sub_max = 5'd3;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (adv && x_last && y_last) state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bpp_log_q   <= 2'd0;
            mode32_q    <= 1'b0;
            stride_q    <= '0;
            line_base_q <= '0;
            word_idx_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sub_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && enable) begin
                bpp_log_q   <= sel_log;
                mode32_q    <= sel_m32;
                stride_q    <= sel_stride;
                line_base_q <= frame_base;
                word_idx_q  <= '0;
                x_q         <= '0;
                y_q         <= '0;
                sub_q       <= '0;
            end else if (issue) begin
                if (x_last) begin
                    x_q         <= '0;
                    y_q         <= y_q + 1'b1;
                    sub_q       <= '0;
                    word_idx_q  <= '0;
                    line_base_q <= line_base_q + stride_q;
                end else begin
                    x_q <= x_q + 1'b1;
                    if (sub_last) begin
                        sub_q      <= '0;
                        word_idx_q <= word_idx_q + c_aw'(1);
                    end else begin
                        sub_q <= sub_q + 5'd1;
                    end
                end
            end
        end
    end

    // S1: a fresh VRAM word is only on vram_d for the first pixel of that word.
    assign w_word    = s1_new_q ? vram_d : word_q;
    assign w_shamt   = s1_sub_q << bpp_log_q;
    assign w_shifted = w_word >> w_shamt;

    always_comb begin
        case (bpp_log_q)
            2'd0:    w_mask = 8'h01;
            2'd1:    w_mask = 8'h03;
            2'd2:    w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_field  = w_shifted[7:0] & w_mask;
    assign w_unused = ^{pram_d[31:24], w_shifted[31:8], w_word[31:24]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_new_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_sub_q    <= '0;
            word_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_eol_q    <= 1'b0;
            s2_direct_q <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pixel_q <= '0;
        end else if (adv) begin
            s1_valid_q <= issue;
            s1_new_q   <= issue & (sub_q == 5'd0);
            s1_sof_q   <= issue & (x_q == '0) & (y_q == '0);
            s1_eol_q   <= issue & x_last;
            s1_sub_q   <= sub_q;
            if (s1_valid_q) begin
                word_q <= w_word;
            end
            s2_valid_q  <= s1_valid_q;
            s2_sof_q    <= s1_valid_q & s1_sof_q;
            s2_eol_q    <= s1_valid_q & s1_eol_q;
            s2_direct_q <= w_word[23:0];
            out_valid_q <= s2_valid_q;
            out_sof_q   <= s2_valid_q & s2_sof_q;
            out_eol_q   <= s2_valid_q & s2_eol_q;
            if (s2_valid_q) begin
                out_pixel_q <= mode32_q ? s2_direct_q : pram_d[23:0];
            end
        end
    end

    assign vram_a     = line_base_q + word_idx_q;
    assign vram_en    = issue & (sub_q == 5'd0);
    assign pram_a     = PRAM_ADDR_WIDTH'(w_field);
    assign pram_en    = adv & s1_valid_q & ~mode32_q;
    assign out_pixel  = out_pixel_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = (state_q == S_DRAIN) & pipe_empty;

endmodule
`default_nettype wire

// File: tb/tb_ava_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ava_pixel_fetch
// Brief   : directed self-checking bench for ava_pixel_fetch (64x2 frame)
// Revision: 1.0  initial release
// ============================================================================
module tb_ava_pixel_fetch;

    localparam int H    = 64;
    localparam int V    = 2;
    localparam int AW   = 17;
    localparam int PW   = 8;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [2:0]    bpp_sel;
    logic [AW-1:0] frame_base;
    logic [AW-1:0] vram_a;
    logic          vram_en;
    logic [31:0]   vram_d = '0;
    logic [PW-1:0] pram_a;
    logic          pram_en;
    logic [31:0]   pram_d = '0;
    logic [23:0]   out_pixel;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          frame_done;

    logic [31:0] vmem [0:1023];
    logic [31:0] pmem [0:255];

    int checks   = 0;
    int failures = 0;
    logic stall_mode = 1'b0;

    int cyc = 0;
    int first_en = -1;
    int first_val = -1;
    int stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_out = '0;
    logic [25:0] pix_q [$];
    int          acc_cyc_q [$];
    logic [AW-1:0] rd_addr_q [$];
    int          rd_cyc_q [$];
    int          done_cyc_q [$];

    ava_pixel_fetch #(
        .H_RES(H), .V_RES(V), .VRAM_ADDR_WIDTH(AW), .PRAM_ADDR_WIDTH(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bpp_sel(bpp_sel),
        .frame_base(frame_base), .vram_a(vram_a), .vram_en(vram_en),
        .vram_d(vram_d), .pram_a(pram_a), .pram_en(pram_en), .pram_d(pram_d),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (vram_en) vram_d <= vmem[vram_a[9:0]];
    always @(posedge clk) if (pram_en) pram_d <= pmem[pram_a];
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Observation happens mid-cycle, after ready and all outputs have settled.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || {out_sof, out_eol, out_pixel} !== prev_out))
                stab_err <= stab_err + 1;
            if (vram_en) begin
                rd_addr_q.push_back(vram_a);
                rd_cyc_q.push_back(cyc);
                if (first_en < 0) first_en <= cyc;
            end
            if (out_valid && first_val < 0) first_val <= cyc;
            if (out_valid && out_ready) begin
                pix_q.push_back({out_sof, out_eol, out_pixel});
                acc_cyc_q.push_back(cyc);
            end
            if (frame_done) done_cyc_q.push_back(cyc);
            prev_stall <= out_valid & ~out_ready;
            prev_out   <= {out_sof, out_eol, out_pixel};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] exp_pix(input int kind, input int i);
        logic [23:0] p;
        case (kind)
            0:       p = 24'(i % H);
            1:       p = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            2:       p = 24'h123456 + 24'(i);
            default: p = 24'(i % 2);
        endcase
        return {(i == 0), (i % H == H - 1), p};
    endfunction

    task automatic check_frame(input int b, input int kind, input string tag);
        int errs = 0;
        check({tag, " count"}, pix_q.size() - b, NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (b + i >= pix_q.size() || pix_q[b + i] !== exp_pix(kind, i)) errs++;
        end
        check({tag, " data"}, errs, 0);
    endtask

    task automatic start_frame();
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int k = 0; k < 3000 && done_cyc_q.size() < target; k++) @(negedge clk);
        check({tag, " frame_done seen"}, done_cyc_q.size() >= target, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int pb, rb, db;
        for (int k = 0; k < 1024; k++) vmem[k] = '0;
        for (int k = 0; k < 256; k++) pmem[k] = 32'(k);
        for (int k = 0; k < H / 4; k++) begin
            vmem[100 + k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            vmem[116 + k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        end
        for (int k = 0; k < 4; k++) vmem[200 + k] = 32'hAAAAAAAA;
        for (int k = 0; k < NPIX; k++) vmem[300 + k] = 32'hFF000000 | 32'(24'h123456 + 24'(k));

        reset_n = 1'b0; enable = 1'b0; bpp_sel = 3'd3; frame_base = 17'd100;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset vram_en", vram_en, 0);
        check("reset pram_en", pram_en, 0);
        check("reset out_pixel", out_pixel, 0);
        check("reset sof/eol/done", {out_sof, out_eol, frame_done}, 0);
        check("reset vram_a", vram_a, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8 bpp, identity palette, no stall
        pb = pix_q.size(); rb = rd_addr_q.size(); db = done_cyc_q.size();
        start_frame();
        wait_done(db + 1, "8bpp");
        check("first valid latency", first_val - first_en, 3);
        check_frame(pb, 0, "8bpp");
        check("8bpp done after last accept", done_cyc_q[db] - acc_cyc_q[pb + NPIX - 1], 1);
        check("8bpp reads", rd_addr_q.size() - rb, 32);
        check("8bpp first addr", rd_addr_q[rb], 100);
        check("8bpp line1 addr", rd_addr_q[rb + 16], 116);

        // 1 bpp, two-colour palette
        pmem[1] = 32'h00FFFFFF;
        bpp_sel = 3'd0; frame_base = 17'd200;
        pb = pix_q.size(); rb = rd_addr_q.size(); db = done_cyc_q.size();
        start_frame();
        wait_done(db + 1, "1bpp");
        check_frame(pb, 1, "1bpp");
        check("1bpp reads", rd_addr_q.size() - rb, 4);
        check("1bpp line1 addr", rd_addr_q[rb + 2], 202);
        pmem[1] = 32'd1;

        // 32 bpp direct
        bpp_sel = 3'd4; frame_base = 17'd300;
        pb = pix_q.size(); rb = rd_addr_q.size(); db = done_cyc_q.size();
        start_frame();
        wait_done(db + 1, "32bpp");
        check_frame(pb, 2, "32bpp");
        check("32bpp reads", rd_addr_q.size() - rb, NPIX);
        check("32bpp back-to-back reads", rd_cyc_q[rb + NPIX - 1] - rd_cyc_q[rb], NPIX - 1);
        check("32bpp last addr", rd_addr_q[rb + NPIX - 1], 300 + NPIX - 1);

        // 8 bpp with random backpressure
        stall_mode = 1'b1;
        bpp_sel = 3'd3; frame_base = 17'd100;
        pb = pix_q.size(); db = done_cyc_q.size();
        start_frame();
        wait_done(db + 1, "stall");
        check_frame(pb, 0, "stall");
        check("stall output stability", stab_err, 0);
        stall_mode = 1'b0;

        // config change mid-frame only affects the following frame
        pb = pix_q.size(); rb = rd_addr_q.size(); db = done_cyc_q.size();
        start_frame();
        for (int k = 0; k < 500 && pix_q.size() < pb + 10; k++) @(negedge clk);
        bpp_sel = 3'd0; frame_base = 17'd200;
        wait_done(db + 1, "midchg old");
        check_frame(pb, 0, "midchg old");
        check("midchg old reads", rd_addr_q.size() - rb, 32);
        pb = pix_q.size(); rb = rd_addr_q.size(); db = done_cyc_q.size();
        start_frame();
        wait_done(db + 1, "midchg new");
        check_frame(pb, 3, "midchg new");
        check("midchg new first addr", rd_addr_q[rb], 200);

        // reset in the middle of a frame, then restart
        bpp_sel = 3'd3; frame_base = 17'd100;
        pb = pix_q.size();
        @(negedge clk); enable = 1'b1;
        for (int k = 0; k < 500 && pix_q.size() < pb + 40; k++) @(negedge clk);
        check("reached pixel 40", pix_q.size() >= pb + 40, 1);
        reset_n = 1'b0;
        #1;
        check("midreset outputs", {out_valid, vram_en, pram_en, out_sof, out_eol, frame_done}, 0);
        check("midreset out_pixel", out_pixel, 0);
        @(negedge clk);
        pb = pix_q.size(); db = done_cyc_q.size();
        reset_n = 1'b1;
        @(negedge clk); enable = 1'b0;
        wait_done(db + 1, "restart");
        check_frame(pb, 0, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ava_pixel_fetch.md
Name: ava_pixel_fetch

Overview:
- Parametrised successor to the fixed direct-mode renderer.
- Scans a frame of H_RES x V_RES pixels from VRAM at a runtime-selectable depth of 1/2/4/8 bpp (palette-indexed) or 32 bpp (direct RGB).
- Emits 24-bit pixels on a valid/ready stream that feeds the pixel CDC FIFO.
- Sits between VRAM/PRAM read ports and the FIFO write side, in the system clock domain.

Parameters:
- H_RES, 640, active pixels per line; H_RES*bpp must be a multiple of 32 for every supported bpp.
- V_RES, 480, active lines per frame.
- VRAM_ADDR_WIDTH, 17, VRAM word address width.
- PRAM_ADDR_WIDTH, 8, palette address width; 8 bpp uses all entries.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  frame start permission; sampled only at frame boundary
- bpp_sel  in  3  0:1bpp 1:2bpp 2:4bpp 3:8bpp 4:32bpp; 5-7 treated as 8bpp; sampled at frame boundary
- frame_base  in  VRAM_ADDR_WIDTH  word address of pixel (0,0); sampled at frame boundary
- vram_a  out  VRAM_ADDR_WIDTH  VRAM read word address
- vram_en  out  1  VRAM read enable; do2 holds when low
- vram_d  in  32  VRAM read data, valid 1 cycle after en
- pram_a  out  PRAM_ADDR_WIDTH  palette index
- pram_en  out  1  palette read enable; output holds when low
- pram_d  in  32  palette data, colour in [23:0], valid 1 cycle after en
- out_pixel  out  24  RGB pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  consumer accepts when valid&ready
- out_sof  out  1  qualifies first pixel of frame (x=0,y=0)
- out_eol  out  1  qualifies last pixel of each line
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; counters cleared. Deassertion is synchronised by the integrator.
- FSM states:
  - IDLE: if enable=1, latch bpp_sel/frame_base, go to RUN with x=y=0.
  - RUN: fetch pixels. Last pixel issued goes to DRAIN.
  - DRAIN: wait until the pipeline is empty. Then pulse frame_done, return to IDLE. IDLE re-evaluates enable on the next cycle, so back-to-back frames have a 2-cycle gap.
- Global advance: adv = ~out_valid | out_ready. All pipeline registers, vram_en and pram_en qualify with adv. No skid buffer is needed because RAM outputs hold when en=0.
- Pipeline:
  - S0 (cycle n): issue vram_a with vram_en=adv, only when sub-pixel index = 0.
  - S1 (n+1): capture vram_d into word_reg on a new word, else reuse word_reg. Extract pixel field LSB-first (pixel k occupies bits [k*bpp +: bpp]), zero-extend to pram_a. Issue pram_en.
  - S2 (n+2): pram_d[23:0] (indexed) or the word's [23:0] (32bpp, delayed one register to match latency) is registered to out_pixel. out_valid=1 from n+3.
  - Fixed latency is 3 cycles with no stall; 1 pixel/cycle sustained.
- sof/eol propagate through the pipeline alongside each pixel.
- Addressing:
  - vram_a = line_base + word_idx.
  - line_base starts at frame_base and adds H_RES*bpp/32 at each line end. Adders only, no multiplier.
  - Wraps modulo 2^VRAM_ADDR_WIDTH.
- Counters: x wraps H_RES-1 -> 0 with y+1; y=V_RES-1 at x wrap ends issuance.
- enable deasserted mid-frame: ignored; the frame completes.
- bpp_sel/frame_base change mid-frame: ignored until next IDLE.
- out_ready low with out_valid high: out_pixel/sof/eol stable, no address or en change.

Test Plan:
- H_RES=64, V_RES=2, 8bpp, VRAM word k = {4k+3,4k+2,4k+1,4k}, identity palette, out_ready=1 -> first out_valid 3 cycles after RUN entry; pixels 0x000000..0x00003F per line in order; eol on x=63; sof once; frame_done after 128th accept.
- 1bpp, word 0xAAAAAAAA, palette[0]=0x000000, palette[1]=0xFFFFFF -> alternating 0x000000/0xFFFFFF; exactly 2 vram_en reads per line; line 1 address = frame_base+2.
- 32bpp, word = 0xFF123456 -> out_pixel 0x123456; pram_en may toggle but pram_d ignored; vram reads every cycle.
- Random out_ready at 30% -> sequence identical to the no-stall run; out_pixel stable while valid&~ready; no dropped or duplicated pixels.
- Change bpp_sel 3->0 and frame_base at pixel 10 -> current frame finishes at 8bpp from the old base; next frame uses 1bpp and the new base.
- Assert reset_n=0 at pixel 40 -> all outputs 0 immediately; after release with enable=1, the frame restarts at sof with pixel (0,0).
